// File: rtl/int_alu_pkg.sv
// Shared constants and types for the integer ALU bus responder.
package int_alu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned OP_W   = 32;
  localparam int unsigned OPC_W  = 8;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned SEL_W  = 4;

  // Module-select values carried on address[15:12]
  localparam logic [SEL_W-1:0] MAIN_MEM_EN   = 4'd0;
  localparam logic [SEL_W-1:0] INSTR_MEM_EN  = 4'd1;
  localparam logic [SEL_W-1:0] MATRIX_ALU_EN = 4'd2;
  localparam logic [SEL_W-1:0] INT_ALU_EN    = 4'd3;
  localparam logic [SEL_W-1:0] REGISTER_EN   = 4'd4;
  localparam logic [SEL_W-1:0] EXECUTE_EN    = 4'd5;

  // Register indices carried on address[11:0]
  localparam logic [IDX_W-1:0] REG_SOURCE_1   = 12'd0;
  localparam logic [IDX_W-1:0] REG_SOURCE_2   = 12'd1;
  localparam logic [IDX_W-1:0] REG_RESULT     = 12'd2;
  localparam logic [IDX_W-1:0] REG_STATUS_IN  = 12'd3;
  localparam logic [IDX_W-1:0] REG_STATUS_OUT = 12'd4;

  // Opcodes written to status_in[7:0]
  localparam logic [OPC_W-1:0] OPC_ADD = 8'h10;
  localparam logic [OPC_W-1:0] OPC_SUB = 8'h11;
  localparam logic [OPC_W-1:0] OPC_MUL = 8'h12;
  localparam logic [OPC_W-1:0] OPC_DIV = 8'h13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Operation snapshot taken when a start is accepted
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
  } alu_op_t;

  // Sign-extend a 32-bit result onto the data bus width
  function automatic logic [DATA_W-1:0] sext_word(input logic [OP_W-1:0] w);
    return {{(DATA_W - OP_W){w[OP_W-1]}}, w};
  endfunction

endpackage

// File: rtl/int_alu_divider.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
module int_alu_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = WIDTH
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_STEPS + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shift_c;
  logic [WIDTH:0]   diff_c;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    shift_c = {rem_q, quotient[WIDTH-1]};
    diff_c  = shift_c - {1'b0, dsr_q};
  end

  // Step engine; done is high in the cycle whose closing edge performs the final step
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      quotient <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      quotient <= dividend;
      rem_q    <= '0;
      dsr_q    <= divisor;
      cnt_q    <= CNT_W'(DIV_STEPS);
      busy     <= 1'b1;
      done     <= (DIV_STEPS == 1);
    end else if (busy) begin
      if (!diff_c[WIDTH]) begin
        rem_q    <= diff_c[WIDTH-1:0];
        quotient <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        rem_q    <= shift_c[WIDTH-1:0];
        quotient <= {quotient[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CNT_W'(1);
      busy  <= (cnt_q != CNT_W'(1));
      done  <= (cnt_q == CNT_W'(2));
    end
  end

endmodule

// File: rtl/int_alu.sv
// Integer ALU bus responder: operand/opcode registers, one-cycle add/sub/mul, iterative divide.
module int_alu
  import int_alu_pkg::*;
#(
  parameter int unsigned      DIV_STEPS = 32,
  parameter logic [SEL_W-1:0] MOD_ID    = INT_ALU_EN
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] address,
  input  logic              nRead,
  input  logic              nWrite,
  input  logic [DATA_W-1:0] ExeDataOut,
  output logic [DATA_W-1:0] IntDataOut
);

  logic              sel_c;
  logic              wr_c;
  logic              rd_c;
  logic [IDX_W-1:0]  idx_c;
  logic              start_c;
  logic              div_start_c;
  logic [OPC_W-1:0]  wr_opc_c;
  logic [OP_W-1:0]   a_abs_c;
  logic [OP_W-1:0]   b_abs_c;
  logic [OP_W-1:0]   alu_c;
  logic [DATA_W-1:0] commit_c;
  logic [DATA_W-1:0] rdata_c;

  logic [DATA_W-1:0] source_1;
  logic [DATA_W-1:0] source_2;
  logic [DATA_W-1:0] result;
  logic              status_out;
  state_t            state;
  alu_op_t           op_q;
  logic              q_neg;

  logic              div_busy;
  logic              div_done;
  logic [OP_W-1:0]   div_quo;

  // Bus decode and start acceptance (starts only land while idle)
  always_comb begin
    sel_c       = (address[ADDR_W-1:ADDR_W-SEL_W] == MOD_ID);
    idx_c       = address[IDX_W-1:0];
    wr_c        = sel_c && !nWrite;
    rd_c        = sel_c && !nRead;
    wr_opc_c    = ExeDataOut[OPC_W-1:0];
    start_c     = wr_c && (idx_c == REG_STATUS_IN) && (state == IDLE);
    div_start_c = start_c && (wr_opc_c == OPC_DIV) && (source_2[OP_W-1:0] != '0);
    a_abs_c     = source_1[OP_W-1] ? (~source_1[OP_W-1:0] + OP_W'(1)) : source_1[OP_W-1:0];
    b_abs_c     = source_2[OP_W-1] ? (~source_2[OP_W-1:0] + OP_W'(1)) : source_2[OP_W-1:0];
  end

  int_alu_divider #(
    .WIDTH     (OP_W),
    .DIV_STEPS (DIV_STEPS)
  ) u_divider (
    .Clk      (Clk),
    .nReset   (nReset),
    .start    (div_start_c),
    .dividend (a_abs_c),
    .divisor  (b_abs_c),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Result datapath from the latched operation; 0x80000000/-1 falls out of the magnitude path
  always_comb begin
    alu_c = '0;
    case (op_q.opcode)
      OPC_ADD: alu_c = op_q.a + op_q.b;
      OPC_SUB: alu_c = op_q.a - op_q.b;
      OPC_MUL: alu_c = op_q.a * op_q.b;
      OPC_DIV: alu_c = q_neg ? (~div_quo + OP_W'(1)) : div_quo;
      default: alu_c = '0;
    endcase
    if ((op_q.opcode == OPC_DIV) && (op_q.b == '0)) begin
      commit_c = '1;
    end else begin
      commit_c = sext_word(alu_c);
    end
  end

  // Register read mux; write-only and unmapped indices read as zero
  always_comb begin
    rdata_c = '0;
    case (idx_c)
      REG_SOURCE_1:   rdata_c = source_1;
      REG_SOURCE_2:   rdata_c = source_2;
      REG_RESULT:     rdata_c = result;
      REG_STATUS_OUT: rdata_c = {{(DATA_W - 1){1'b0}}, status_out};
      default:        rdata_c = '0;
    endcase
  end

  // Read port: selected reads capture the pre-write register value
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      IntDataOut <= '0;
    end else if (rd_c) begin
      IntDataOut <= rdata_c;
    end
  end

  // Operand registers, writable at any time
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      source_1 <= '0;
      source_2 <= '0;
    end else if (wr_c) begin
      if (idx_c == REG_SOURCE_1) source_1 <= ExeDataOut;
      if (idx_c == REG_SOURCE_2) source_2 <= ExeDataOut;
    end
  end

  // Control FSM: latch on start, wait out the divider, commit result and status
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      op_q       <= '0;
      q_neg      <= 1'b0;
      result     <= '0;
      status_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            status_out  <= 1'b0;
            op_q.opcode <= wr_opc_c;
            op_q.a      <= source_1[OP_W-1:0];
            op_q.b      <= source_2[OP_W-1:0];
            q_neg       <= source_1[OP_W-1] ^ source_2[OP_W-1];
            state       <= div_start_c ? DIVIDE : FINISH;
          end
        end
        DIVIDE: begin
          // Leaving on !busy as well keeps the FSM from ever stalling here
          if (div_done || !div_busy) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          result     <= commit_c;
          status_out <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_alu.sv
// Self-checking bench for int_alu with a transaction-level reference model.
module tb_int_alu;

  logic         Clk = 1'b0;
  logic         nReset;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;
  logic [255:0] ExeDataOut;
  logic [255:0] IntDataOut;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference model state
  logic [255:0] m_src1, m_src2, m_result, m_last, m_pend;
  logic         m_status;
  bit           m_pending;
  int           m_commit_at;

  int_alu dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .address    (address),
    .nRead      (nRead),
    .nWrite     (nWrite),
    .ExeDataOut (ExeDataOut),
    .IntDataOut (IntDataOut)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] sx(input int v);
    logic [31:0] w;
    w = v;
    return {{224{w[31]}}, w};
  endfunction

  // Signed 32-bit reference arithmetic
  function automatic logic [255:0] ref_op(input logic [7:0] op, input logic [31:0] au, input logic [31:0] bu);
    int a, b, r;
    a = au;
    b = bu;
    r = 0;
    case (op)
      8'h10: r = a + b;
      8'h11: r = a - b;
      8'h12: r = a * b;
      8'h13: begin
        if (b == 0) return '1;
        if (au == 32'h8000_0000 && b == -1) r = a;
        else r = a / b;
      end
      default: return '0;
    endcase
    return sx(r);
  endfunction

  task automatic model_reset();
    m_src1 = '0; m_src2 = '0; m_result = '0; m_last = '0; m_pend = '0;
    m_status = 1'b0; m_pending = 1'b0; m_commit_at = 0;
  endtask

  // Apply any commit that happened on an edge before edge k
  task automatic model_advance(input int k);
    if (m_pending && m_commit_at < k) begin
      m_result  = m_pend;
      m_status  = 1'b1;
      m_pending = 1'b0;
    end
  endtask

  task automatic wr(input logic [3:0] mod, input logic [11:0] idx, input logic [255:0] d);
    @(negedge Clk);
    address = {mod, idx}; nWrite = 1'b0; nRead = 1'b1; ExeDataOut = d;
    @(posedge Clk); #1;
    nWrite = 1'b1;
    model_advance(edge_n);
    if (mod == 4'h3) begin
      case (idx)
        12'd0: m_src1 = d;
        12'd1: m_src2 = d;
        12'd3: if (!m_pending) begin
          m_pend      = ref_op(d[7:0], m_src1[31:0], m_src2[31:0]);
          m_commit_at = edge_n + ((d[7:0] == 8'h13 && m_src2[31:0] != 0) ? 33 : 1);
          m_pending   = 1'b1;
          m_status    = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic rd(input logic [3:0] mod, input logic [11:0] idx, input string tag, output logic [255:0] got);
    @(negedge Clk);
    address = {mod, idx}; nRead = 1'b0; nWrite = 1'b1;
    @(posedge Clk); #1;
    nRead = 1'b1;
    model_advance(edge_n);
    if (mod == 4'h3) begin
      case (idx)
        12'd0:   m_last = m_src1;
        12'd1:   m_last = m_src2;
        12'd2:   m_last = m_result;
        12'd4:   m_last = {255'd0, m_status};
        default: m_last = '0;
      endcase
    end
    got = IntDataOut;
    check(tag, got, m_last);
  endtask

  task automatic poll(output int polls);
    logic [255:0] s;
    polls = 0;
    do begin
      rd(4'h3, 12'd4, "status", s);
      polls++;
    end while (s[0] == 1'b0 && polls < 80);
    if (s[0] == 1'b0) check("poll_timeout", s, 256'd1);
  endtask

  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [7:0] op,
                        output logic [255:0] res, output int polls);
    wr(4'h3, 12'd0, a);
    wr(4'h3, 12'd1, b);
    wr(4'h3, 12'd3, {248'd0, op});
    poll(polls);
    rd(4'h3, 12'd2, "result", res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [255:0] rand_wide(input logic [31:0] lo);
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    v[31:0] = lo;
    return v;
  endfunction

  logic [255:0] res, tmp;
  int polls;
  logic [7:0] opc;

  initial begin
    nReset = 1'b0; address = '0; nRead = 1'b1; nWrite = 1'b1; ExeDataOut = '0;
    model_reset();
    #1;
    check("reset_out", IntDataOut, '0);
    #22 nReset = 1'b1;
    rd(4'h3, 12'd4, "rst_status", tmp);
    rd(4'h3, 12'd2, "rst_result", tmp);

    // Add with a negative result, one-cycle completion
    run_op(sx(5), sx(-7), 8'h10, res, polls);
    check("add_val", res, {{255{1'b1}}, 1'b0});
    check("add_polls", 256'(polls), 256'd2);

    // Divide with negative dividend: 33 busy polls then done
    run_op(sx(-100), sx(7), 8'h13, res, polls);
    check("div_val", res, sx(-14));
    check("div_polls", 256'(polls), 256'd34);

    run_op(sx(7), sx(0), 8'h13, res, polls);
    check("div0_val", res, '1);
    check("div0_polls", 256'(polls), 256'd2);

    run_op(sx(32'h7FFF_FFFF), sx(1), 8'h10, res, polls);
    check("add_wrap", res, sx(32'h8000_0000));
    run_op(sx(65536), sx(65536), 8'h12, res, polls);
    check("mul_wrap", res, '0);
    run_op(sx(32'h8000_0000), sx(-1), 8'h13, res, polls);
    check("div_ovf", res, sx(32'h8000_0000));
    run_op(sx(9), sx(4), 8'h77, res, polls);
    check("bad_opc", res, '0);

    // Start and operand writes while dividing are ignored by the running op
    wr(4'h3, 12'd0, sx(1000));
    wr(4'h3, 12'd1, sx(10));
    wr(4'h3, 12'd3, 256'h13);
    repeat (3) @(posedge Clk);
    wr(4'h3, 12'd1, sx(3));
    wr(4'h3, 12'd3, 256'h10);
    poll(polls);
    rd(4'h3, 12'd2, "busy_result", res);
    check("busy_div", res, sx(100));
    rd(4'h3, 12'd1, "busy_src2", tmp);

    // Reset in the middle of a divide
    wr(4'h3, 12'd0, sx(-100));
    wr(4'h3, 12'd1, sx(7));
    rd(4'h3, 12'd0, "pre_rst_src1", tmp);
    wr(4'h3, 12'd3, 256'h13);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_out", IntDataOut, '0);
    @(negedge Clk);
    nReset = 1'b1;
    rd(4'h3, 12'd4, "mid_rst_status", tmp);
    rd(4'h3, 12'd2, "mid_rst_result", tmp);
    rd(4'h3, 12'd0, "mid_rst_src1", tmp);

    // Selection and unmapped indices
    wr(4'h3, 12'd0, sx(42));
    rd(4'h3, 12'd0, "sel_src1", tmp);
    wr(4'h2, 12'd0, 256'hDEAD_BEEF);
    wr(4'h2, 12'd3, 256'h10);
    rd(4'h3, 12'd0, "unsel_wr_src1", tmp);
    rd(4'h2, 12'd0, "unsel_rd_hold", tmp);
    check("unsel_hold_val", tmp, sx(42));
    rd(4'h3, 12'd9, "idx9", tmp);
    check("idx9_zero", tmp, '0);
    rd(4'h3, 12'd4, "unsel_status", tmp);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: opc = 8'h10;
        1: opc = 8'h11;
        2: opc = 8'h12;
        3, 4: opc = 8'h13;
        default: opc = 8'($urandom);
      endcase
      wr(4'h3, 12'd0, rand_wide(pick()));
      wr(4'h3, 12'd1, rand_wide(pick()));
      wr(4'h3, 12'd3, {248'd0, opc});
      if ($urandom_range(0, 3) == 0) begin
        wr(4'h3, 12'd1, rand_wide(pick()));
        wr(4'h3, 12'd3, {248'd0, 8'h10 + 8'($urandom_range(0, 3))});
      end
      poll(polls);
      rd(4'h3, 12'd2, "rand_result", res);
      if ($urandom_range(0, 1) == 1) rd(4'h3, 12'd1, "rand_src2", tmp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
